// File: rtl/reg_file_sync_np.sv
// Synchronous register file: one write port, N_READ read ports, per-register written tracking,
// saturating write counter, optional zero register, write-to-read bypass and registered read.
module reg_file_sync_np #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       RWEN,
    input  logic [ADDR_W-1:0]          DirWrite,
    input  logic [DATA_W-1:0]          DatoNuevo,
    input  logic [N_READ*ADDR_W-1:0]   Dir,
    output logic [N_READ*DATA_W-1:0]   Dato,
    output logic [N_READ-1:0]          Valido,
    output logic [15:0]                WrCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         written_q, written_d;
    logic [15:0]              wr_count_q, wr_count_d;
    logic                     wr_acc;
    logic [N_READ*DATA_W-1:0] raw_dato;
    logic [N_READ-1:0]        raw_valido;

    // RST drops a coincident write; register 0 swallows writes when hardwired
    always_comb begin
        wr_acc = RWEN && !RST && !((ZERO_REG != 0) && (DirWrite == '0));
    end

    always_comb begin
        mem_d      = mem_q;
        written_d  = written_q;
        wr_count_d = wr_count_q;
        if (wr_acc) begin
            mem_d[DirWrite]     = DatoNuevo;
            written_d[DirWrite] = 1'b1;
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q  <= '0;
            wr_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            written_q  <= written_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign WrCount = wr_count_q;

    for (genvar p = 0; p < N_READ; p++) begin : g_port
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] port_dato;
        logic              port_valido;

        assign rd_addr = Dir[p*ADDR_W +: ADDR_W];

        always_comb begin
            port_dato   = mem_q[rd_addr];
            port_valido = written_q[rd_addr];
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                port_dato   = '0;
                port_valido = 1'b1;
            end else if ((BYPASS != 0) && wr_acc && (DirWrite == rd_addr)) begin
                port_dato   = DatoNuevo;
                port_valido = 1'b1;
            end
        end

        assign raw_dato[p*DATA_W +: DATA_W] = port_dato;
        assign raw_valido[p]                = port_valido;
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [N_READ*DATA_W-1:0] dato_q, dato_d;
        logic [N_READ-1:0]        valido_q, valido_d;

        always_comb begin
            dato_d   = raw_dato;
            valido_d = raw_valido;
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                dato_q   <= '0;
                valido_q <= '0;
            end else begin
                dato_q   <= dato_d;
                valido_q <= valido_d;
            end
        end

        assign Dato   = dato_q;
        assign Valido = valido_q;
    end else begin : g_rd_comb
        assign Dato   = raw_dato;
        assign Valido = raw_valido;
    end

endmodule

// File: tb/tb_reg_file_sync_np.sv
// Directed bench: three configurations of reg_file_sync_np driven with shared stimulus,
// checked against hand-computed tables plus sequences for registered read and counter limits.
module tb_reg_file_sync_np;

    logic        CLK;
    logic        RST;
    logic        RWEN;
    logic [4:0]  DirWrite;
    logic [31:0] DatoNuevo;
    logic [4:0]  dir0, dir1;
    logic [9:0]  Dir;

    logic [63:0] dato_a, dato_b, dato_c;
    logic [1:0]  val_a, val_b, val_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    assign Dir = {dir1, dir0};

    // a: zero reg, bypass, combinational read
    reg_file_sync_np #(.ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_a (
        .CLK(CLK), .RST(RST), .RWEN(RWEN), .DirWrite(DirWrite), .DatoNuevo(DatoNuevo),
        .Dir(Dir), .Dato(dato_a), .Valido(val_a), .WrCount(cnt_a));

    // b: no zero reg, bypass, registered read
    reg_file_sync_np #(.ZERO_REG(0), .BYPASS(1), .READ_REG(1)) u_b (
        .CLK(CLK), .RST(RST), .RWEN(RWEN), .DirWrite(DirWrite), .DatoNuevo(DatoNuevo),
        .Dir(Dir), .Dato(dato_b), .Valido(val_b), .WrCount(cnt_b));

    // c: zero reg, no bypass, combinational read
    reg_file_sync_np #(.ZERO_REG(1), .BYPASS(0), .READ_REG(0)) u_c (
        .CLK(CLK), .RST(RST), .RWEN(RWEN), .DirWrite(DirWrite), .DatoNuevo(DatoNuevo),
        .Dir(Dir), .Dato(dato_c), .Valido(val_c), .WrCount(cnt_c));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  v;
        logic [15:0] c;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        chk;
        exp_t        ea;
        exp_t        eb;
        exp_t        ec;
    } vec_t;

    function automatic exp_t e(input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] v, input logic [15:0] c);
        exp_t x;
        x.d0 = d0; x.d1 = d1; x.v = v; x.c = c;
        return x;
    endfunction

    function automatic vec_t mk(input logic rst, input logic wen, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1,
                                input logic chk, input exp_t ea, input exp_t eb, input exp_t ec);
        vec_t x;
        x.rst = rst; x.wen = wen; x.wa = wa; x.wd = wd; x.r0 = r0; x.r1 = r1;
        x.chk = chk; x.ea = ea; x.eb = eb; x.ec = ec;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input int k, input logic [63:0] dato,
                           input logic [1:0] val, input logic [15:0] cnt, input exp_t x);
        chk($sformatf("%s v%0d dato0", tag, k), dato[31:0], x.d0);
        chk($sformatf("%s v%0d dato1", tag, k), dato[63:32], x.d1);
        chk($sformatf("%s v%0d valido", tag, k), {30'd0, val}, {30'd0, x.v});
        chk($sformatf("%s v%0d wrcount", tag, k), {16'd0, cnt}, {16'd0, x.c});
    endtask

    task automatic drive(input logic rst, input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
        RST = rst; RWEN = wen; DirWrite = wa; DatoNuevo = wd; dir0 = r0; dir1 = r1;
    endtask

    vec_t tbl [15];

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // a and c are sampled before the edge of their vector; b shows the previous vector's read
        tbl[0]  = mk(1, 1, 3,  32'hDEADBEEF, 3, 0, 0,
                     e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0));
        tbl[1]  = mk(0, 0, 0,  32'h0, 3, 0, 1,
                     e(0, 0, 2'b10, 0), e(0, 0, 2'b00, 0), e(0, 0, 2'b10, 0));
        tbl[2]  = mk(0, 1, 7,  32'h12345678, 7, 31, 1,
                     e(32'h12345678, 0, 2'b01, 0), e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0));
        tbl[3]  = mk(0, 1, 31, 32'hCAFEF00D, 7, 31, 1,
                     e(32'h12345678, 32'hCAFEF00D, 2'b11, 1), e(32'h12345678, 0, 2'b01, 1),
                     e(32'h12345678, 0, 2'b01, 1));
        tbl[4]  = mk(0, 0, 0,  32'h0, 7, 31, 1,
                     e(32'h12345678, 32'hCAFEF00D, 2'b11, 2), e(32'h12345678, 32'hCAFEF00D, 2'b11, 2),
                     e(32'h12345678, 32'hCAFEF00D, 2'b11, 2));
        tbl[5]  = mk(0, 1, 0,  32'hFFFFFFFF, 0, 7, 1,
                     e(0, 32'h12345678, 2'b11, 2), e(32'h12345678, 32'hCAFEF00D, 2'b11, 2),
                     e(0, 32'h12345678, 2'b11, 2));
        tbl[6]  = mk(0, 0, 0,  32'h0, 0, 0, 1,
                     e(0, 0, 2'b11, 2), e(32'hFFFFFFFF, 32'h12345678, 2'b11, 3), e(0, 0, 2'b11, 2));
        tbl[7]  = mk(0, 1, 5,  32'hA5A5A5A5, 5, 6, 1,
                     e(32'hA5A5A5A5, 0, 2'b01, 2), e(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 3),
                     e(0, 0, 2'b00, 2));
        tbl[8]  = mk(0, 0, 0,  32'h0, 5, 6, 1,
                     e(32'hA5A5A5A5, 0, 2'b01, 3), e(32'hA5A5A5A5, 0, 2'b01, 4),
                     e(32'hA5A5A5A5, 0, 2'b01, 3));
        tbl[9]  = mk(0, 1, 5,  32'h11111111, 5, 5, 1,
                     e(32'h11111111, 32'h11111111, 2'b11, 3), e(32'hA5A5A5A5, 0, 2'b01, 4),
                     e(32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11, 3));
        tbl[10] = mk(1, 1, 9,  32'h00000099, 9, 5, 1,
                     e(0, 32'h11111111, 2'b10, 4), e(32'h11111111, 32'h11111111, 2'b11, 5),
                     e(0, 32'h11111111, 2'b10, 4));
        tbl[11] = mk(0, 0, 0,  32'h0, 9, 5, 1,
                     e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0));
        tbl[12] = mk(0, 1, 9,  32'h00000099, 9, 9, 1,
                     e(32'h99, 32'h99, 2'b11, 0), e(0, 0, 2'b00, 0), e(0, 0, 2'b00, 0));
        tbl[13] = mk(0, 0, 0,  32'h0, 9, 31, 1,
                     e(32'h99, 0, 2'b01, 1), e(32'h99, 32'h99, 2'b11, 1), e(32'h99, 0, 2'b01, 1));
        tbl[14] = mk(0, 0, 0,  32'h0, 9, 31, 1,
                     e(32'h99, 0, 2'b01, 1), e(32'h99, 0, 2'b01, 1), e(32'h99, 0, 2'b01, 1));

        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            drive(tbl[k].rst, tbl[k].wen, tbl[k].wa, tbl[k].wd, tbl[k].r0, tbl[k].r1);
            #2;
            if (tbl[k].chk) begin
                chk_dut("a", k, dato_a, val_a, cnt_a, tbl[k].ea);
                chk_dut("b", k, dato_b, val_b, cnt_b, tbl[k].eb);
                chk_dut("c", k, dato_c, val_c, cnt_c, tbl[k].ec);
            end
        end

        // Registered read: address change shows up only after the edge ending that cycle
        @(negedge CLK); drive(0, 1, 5'd31, 32'hCAFE0031, 5'd0, 5'd0);
        @(negedge CLK); drive(0, 1, 5'd7,  32'h00000077, 5'd0, 5'd0);
        @(negedge CLK); drive(0, 0, 5'd0,  32'h0,        5'd7, 5'd0);
        @(negedge CLK); drive(0, 0, 5'd0,  32'h0,        5'd31, 5'd0);
        #2;
        chk("b rr before edge", dato_b[31:0], 32'h00000077);
        chk("a comb reg31", dato_a[31:0], 32'hCAFE0031);
        @(posedge CLK); #1;
        chk("b rr after edge", dato_b[31:0], 32'hCAFE0031);

        // Write plus same-address read: b forwards through bypass into the read register
        @(negedge CLK); drive(0, 1, 5'd12, 32'hC0C0C0C0, 5'd12, 5'd0);
        #2;
        chk("b rr wr before edge", dato_b[31:0], 32'hCAFE0031);
        chk("c nobyp old data", dato_c[31:0], 32'h0);
        chk("c nobyp old valid", {31'd0, val_c[0]}, 32'd0);
        @(posedge CLK); #1;
        chk("b rr wr after edge", dato_b[31:0], 32'hC0C0C0C0);
        chk("b rr wr valid", {31'd0, val_b[0]}, 32'd1);

        // Counter saturation
        @(negedge CLK); drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 65536; i++) begin
            @(negedge CLK);
            drive(0, 1, 5'((i % 31) + 1), i, 5'd5, 5'd6);
            if (i == 65534) begin
                #2;
                chk("a count 65534", {16'd0, cnt_a}, 32'h0000FFFE);
            end else if (i == 65535) begin
                #2;
                chk("a count 65535", {16'd0, cnt_a}, 32'h0000FFFF);
            end
        end
        @(negedge CLK); drive(0, 1, 5'd20, 32'h0BADF00D, 5'd5, 5'd6);
        #2;
        chk("a count saturated", {16'd0, cnt_a}, 32'h0000FFFF);
        chk("b count saturated", {16'd0, cnt_b}, 32'h0000FFFF);
        chk("c count saturated", {16'd0, cnt_c}, 32'h0000FFFF);

        // Reset amid continuous writes
        @(negedge CLK); drive(1, 1, 5'd20, 32'h20202020, 5'd5, 5'd6);
        @(negedge CLK); drive(0, 1, 5'd21, 32'h21212121, 5'd5, 5'd6);
        #2;
        chk("a count after rst", {16'd0, cnt_a}, 32'd0);
        chk("c count after rst", {16'd0, cnt_c}, 32'd0);
        chk("a valido after rst", {30'd0, val_a}, 32'd0);
        chk("a dato0 after rst", dato_a[31:0], 32'd0);
        chk("b valido after rst", {30'd0, val_b}, 32'd0);
        chk("b dato after rst", dato_b[31:0], 32'd0);
        @(negedge CLK); drive(0, 0, 5'd0, 32'h0, 5'd21, 5'd20);
        #2;
        chk("a count resumes", {16'd0, cnt_a}, 32'd1);
        chk("b count resumes", {16'd0, cnt_b}, 32'd1);
        chk("c count resumes", {16'd0, cnt_c}, 32'd1);
        chk("a reg21 after rst", dato_a[31:0], 32'h21212121);
        chk("a reg20 dropped", dato_a[63:32], 32'd0);
        chk("a valido resumed", {30'd0, val_a}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sync_np.md
Name: reg_file_sync_np

Overview:
- Parametrised synchronous register file: one write port, N_READ read ports, per-register "written since reset" tracking.
- Successor to the combinational 32x32 two-port register file in the datapath.
- Sits between the decode stage (read addresses) and the writeback stage (write port).
- Adds a clocked write, synchronous clear, optional hardwired zero register, write-to-read bypass and an optional registered-read mode.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
N_READ, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read port
READ_REG, 0, 0 = combinational read; 1 = read data registered with 1-cycle latency

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  synchronous reset, active-high
RWEN  input  1  write enable
DirWrite  input  ADDR_W  write address
DatoNuevo  input  DATA_W  write data
Dir  input  N_READ*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
Dato  output  N_READ*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
Valido  output  N_READ  port i addressed register has been written since reset (constant 1 for reg 0 when ZERO_REG=1)
WrCount  output  16  count of accepted writes since reset, saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset: on a rising CLK edge with RST=1:
  - all registers are cleared to 0;
  - all written bits are cleared;
  - WrCount is set to 0;
  - when READ_REG=1, Dato and Valido are set to 0.
- RST has priority over RWEN in the same cycle; the write is dropped.
- A reset asserted in the middle of a write sequence discards only the write coincident with RST; earlier writes are already committed and are then cleared by the reset.
- Accepted write: RWEN=1, RST=0, and NOT (ZERO_REG=1 and DirWrite=0).
- On an accepted write:
  - REG[DirWrite] <= DatoNuevo at the rising edge;
  - written[DirWrite] <= 1;
  - WrCount increments unless it is already 16'hFFFF.
- A write to register 0 with ZERO_REG=1 is ignored entirely: no data change, no count increment.
- Raw read value, port i:
  - if ZERO_REG=1 and Dir_i=0: value is 0 and valid is 1;
  - else if BYPASS=1 and the write is accepted this cycle and DirWrite=Dir_i: value is DatoNuevo and valid is 1;
  - else: value is REG[Dir_i] and valid is written[Dir_i].
- READ_REG=0: Dato_i and Valido_i follow the raw values combinationally, with zero latency. After reset they reflect cleared contents (0, valid 0) except register 0.
- READ_REG=1: Dato_i and Valido_i capture the raw values at each rising edge (1-cycle latency).
  - The bypass term makes a write in cycle N visible at the output after the edge ending cycle N, identical to reading in cycle N+1 without bypass.
- BYPASS=0 with READ_REG=0: a same-cycle read returns the old contents; new data is visible from the cycle after the edge.
- Several read ports may address the same register; each port receives identical data.
- Any address may be written in every cycle; there is no back-pressure and no busy state.
- Addresses are always in range because depth = 2**ADDR_W.
- X on DatoNuevo with RWEN=0 has no effect.
- Storage is one DATA_W x 2**ADDR_W array plus a 2**ADDR_W-bit written vector; no latches. Read muxes and bypass compare are generated per port.

Test Plan:
- Reset check: drive RST=1 for 1 edge with RWEN=1, DirWrite=3, DatoNuevo=32'hDEADBEEF, then read Dir0=3 -> Dato0=0, Valido0=0, WrCount=0; the coincident write is dropped.
- Basic write/read: write 32'h12345678 to reg 7, write 32'hCAFEF00D to reg 31; next cycle read Dir0=7, Dir1=31 -> Dato0=32'h12345678, Dato1=32'hCAFEF00D, Valido=2'b11, WrCount=2.
- Zero register: write 32'hFFFFFFFF to reg 0 with ZERO_REG=1 -> read Dir0=0 gives 0 and Valido0=1; WrCount unchanged. Same test with ZERO_REG=0 -> reads 32'hFFFFFFFF.
- Bypass: in one cycle, RWEN=1, DirWrite=5, DatoNuevo=32'hA5A5A5A5, Dir0=5, Dir1=6 (reg 6 never written). With BYPASS=1 and READ_REG=0 -> same cycle Dato0=32'hA5A5A5A5, Valido=2'b01. With BYPASS=0 -> Dato0=0 until the following cycle.
- Registered read: with READ_REG=1, change Dir0 from 7 to 31 at cycle N -> Dato0 shows reg 31 contents only after the edge ending cycle N. Write plus same-address read in cycle N -> new value appears after that edge.
- Counter saturation and reset mid-stream: 65,536 accepted writes -> WrCount holds 16'hFFFF. Assert RST for one cycle amid continuous writes -> WrCount=0 and all Valido=0, then counting resumes at 1 on the next accepted write.
